// File: rtl/arb_pkg.sv
// Shared types for the LSU port arbiter and its round-robin picker.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef logic owner_t;

   localparam owner_t OWNER_M0 = 1'b0;
   localparam owner_t OWNER_M1 = 1'b1;

   localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way round-robin picker; on a tie the requester that did
// not win last time is chosen.
module arb_rr_pick
   import arb_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last_owner,
   output logic       grant_valid,
   output owner_t     grant_idx
);

   always_comb begin
      grant_valid = |req;
      grant_idx   = OWNER_M0;
      case (req)
         2'b01:   grant_idx = OWNER_M0;
         2'b10:   grant_idx = OWNER_M1;
         2'b11:   grant_idx = ~last_owner;
         default: grant_idx = OWNER_M0;
      endcase
   end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-master arbiter sharing the single LSU/data-memory port between the core
// (m0) and the debug/loader port (m1). ARB_TIMEOUT_EN adds an ACCESS-state abort.
//
// Handshakes: a requester holds req/wren/addr/wdata stable until its one-cycle
// gnt pulse; o_mem_req stays high with a stable command until the i_mem_ack
// cycle; o_mX_rvalid is a one-cycle completion pulse qualifying rdata and err.
module lsu_arbiter
   import arb_pkg::*;
#(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst,

   input  logic          i_m0_req,
   input  logic          i_m0_wren,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [DW-1:0] i_m0_wdata,
   output logic          o_m0_gnt,
   output logic          o_m0_rvalid,
   output logic [DW-1:0] o_m0_rdata,
   output logic          o_m0_err,

   input  logic          i_m1_req,
   input  logic          i_m1_wren,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [DW-1:0] i_m1_wdata,
   output logic          o_m1_gnt,
   output logic          o_m1_rvalid,
   output logic [DW-1:0] o_m1_rdata,
   output logic          o_m1_err,

   output logic          o_mem_req,
   output logic          o_mem_wren,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic          i_mem_ack,
   input  logic [DW-1:0] i_mem_rdata,

   output logic          o_owner,
   output logic          o_busy,
   output logic [1:0]    o_state
);

   arb_state_t    state;
   owner_t        owner;
   owner_t        last_owner;
   owner_t        pick_idx;
   logic          pick_valid;

   logic          cmd_wren;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          win_wren;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;

   logic          mem_req;
   logic          m0_gnt;
   logic          m1_gnt;
   logic          m0_rvalid;
   logic          m1_rvalid;
   logic [DW-1:0] m0_rdata;
   logic [DW-1:0] m1_rdata;

   logic          done;
   logic          done_err;
   logic [DW-1:0] done_data;

   arb_rr_pick u_pick (
      .req         ({i_m1_req, i_m0_req}),
      .last_owner  (last_owner),
      .grant_valid (pick_valid),
      .grant_idx   (pick_idx)
   );

   assign win_wren  = (pick_idx == OWNER_M1) ? i_m1_wren  : i_m0_wren;
   assign win_addr  = (pick_idx == OWNER_M1) ? i_m1_addr  : i_m0_addr;
   assign win_wdata = (pick_idx == OWNER_M1) ? i_m1_wdata : i_m0_wdata;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt;
   logic       m0_err;
   logic       m1_err;

   // tmo_cnt counts ACCESS cycles already spent without ack; expiry fires on
   // the TIMEOUT_CYCLES-th such cycle, and an ack in that cycle still wins.
   always_comb begin
      done     = 1'b0;
      done_err = 1'b0;
      if (state == ACCESS) begin
         if (i_mem_ack) begin
            done = 1'b1;
         end else if (tmo_cnt == TMO_LIMIT) begin
            done     = 1'b1;
            done_err = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tmo_cnt <= 8'd0;
         m0_err  <= 1'b0;
         m1_err  <= 1'b0;
      end else begin
         m0_err <= 1'b0;
         m1_err <= 1'b0;
         if (state != ACCESS) begin
            tmo_cnt <= 8'd0;
         end else if (!done) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
         if (done && done_err) begin
            if (owner == OWNER_M0) m0_err <= 1'b1;
            else                   m1_err <= 1'b1;
         end
      end
   end

   assign o_m0_err = m0_err;
   assign o_m1_err = m1_err;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;

   always_comb begin
      done     = (state == ACCESS) && i_mem_ack;
      done_err = 1'b0;
   end

   assign o_m0_err = 1'b0;
   assign o_m1_err = 1'b0;
`endif

   // Stores and aborted accesses return zero rather than whatever is on the bus.
   assign done_data = (done_err || cmd_wren) ? '0 : i_mem_rdata;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         owner      <= OWNER_M0;
         last_owner <= OWNER_M1;
         cmd_wren   <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         mem_req    <= 1'b0;
         m0_gnt     <= 1'b0;
         m1_gnt     <= 1'b0;
         m0_rvalid  <= 1'b0;
         m1_rvalid  <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner      <= pick_idx;
                  last_owner <= pick_idx;
                  cmd_wren   <= win_wren;
                  cmd_addr   <= win_addr;
                  cmd_wdata  <= win_wdata;
                  mem_req    <= 1'b1;
                  m0_gnt     <= (pick_idx == OWNER_M0);
                  m1_gnt     <= (pick_idx == OWNER_M1);
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (done) begin
                  mem_req <= 1'b0;
                  state   <= RESP;
                  if (owner == OWNER_M0) begin
                     m0_rvalid <= 1'b1;
                     m0_rdata  <= done_data;
                  end else begin
                     m1_rvalid <= 1'b1;
                     m1_rdata  <= done_data;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign o_m0_gnt    = m0_gnt;
   assign o_m1_gnt    = m1_gnt;
   assign o_m0_rvalid = m0_rvalid;
   assign o_m1_rvalid = m1_rvalid;
   assign o_m0_rdata  = m0_rdata;
   assign o_m1_rdata  = m1_rdata;

   assign o_mem_req   = mem_req;
   assign o_mem_wren  = cmd_wren;
   assign o_mem_addr  = cmd_addr;
   assign o_mem_wdata = cmd_wdata;

   assign o_owner     = owner;
   assign o_busy      = (state != IDLE);
   assign o_state     = state;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter: stimulus pushes expected grants and
// completions, a monitor pops and compares them; a small memory model acks.
module tb_lsu_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_m0_req, i_m0_wren, i_m1_req, i_m1_wren;
   logic [AW-1:0] i_m0_addr, i_m1_addr;
   logic [DW-1:0] i_m0_wdata, i_m1_wdata;
   logic          o_m0_gnt, o_m0_rvalid, o_m0_err;
   logic          o_m1_gnt, o_m1_rvalid, o_m1_err;
   logic [DW-1:0] o_m0_rdata, o_m1_rdata;
   logic          o_mem_req, o_mem_wren;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic          i_mem_ack = 1'b0;
   logic [DW-1:0] i_mem_rdata = '0;
   logic          o_owner, o_busy;
   logic [1:0]    o_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int mem_wait = 0;
   int wcnt     = 0;
   int g0;

   // Expected responses: {requester, err, rdata}; expected grants: requester.
   logic [DW+1:0] exp_q[$];
   logic          gnt_q[$];
   logic [DW+1:0] exp_rsp, act_rsp;
   logic          exp_gnt;

   lsu_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_m0_req    (i_m0_req),
      .i_m0_wren   (i_m0_wren),
      .i_m0_addr   (i_m0_addr),
      .i_m0_wdata  (i_m0_wdata),
      .o_m0_gnt    (o_m0_gnt),
      .o_m0_rvalid (o_m0_rvalid),
      .o_m0_rdata  (o_m0_rdata),
      .o_m0_err    (o_m0_err),
      .i_m1_req    (i_m1_req),
      .i_m1_wren   (i_m1_wren),
      .i_m1_addr   (i_m1_addr),
      .i_m1_wdata  (i_m1_wdata),
      .o_m1_gnt    (o_m1_gnt),
      .o_m1_rvalid (o_m1_rvalid),
      .o_m1_rdata  (o_m1_rdata),
      .o_m1_err    (o_m1_err),
      .o_mem_req   (o_mem_req),
      .o_mem_wren  (o_mem_wren),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_ack   (i_mem_ack),
      .i_mem_rdata (i_mem_rdata),
      .o_owner     (o_owner),
      .o_busy      (o_busy),
      .o_state     (o_state)
   );

   // ---------------- clock / reset ----------------
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;

   // ---------------- helpers ----------------
   function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return {a[15:0], 16'hC0DE};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_gnt(input logic idx);
      int n;
      n = 0;
      tick();
      while (!(idx ? o_m1_gnt : o_m0_gnt) && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) begin
         checks++;
         errors++;
         $display("FAIL wait_gnt: no grant for m%0d within 50 cycles", idx);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (o_busy && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: still busy after 50 cycles");
      end
   endtask

   task automatic drive_m0(input logic req, input logic wren, input logic [AW-1:0] a, input logic [DW-1:0] d);
      i_m0_req = req; i_m0_wren = wren; i_m0_addr = a; i_m0_wdata = d;
   endtask

   task automatic drive_m1(input logic req, input logic wren, input logic [AW-1:0] a, input logic [DW-1:0] d);
      i_m1_req = req; i_m1_wren = wren; i_m1_addr = a; i_m1_wdata = d;
   endtask

   // ---------------- memory model: ack after mem_wait idle cycles (-1 = never) ----
   always @(posedge i_clk) begin
      #1;
      i_mem_ack = 1'b0;
      if (i_rst || !o_mem_req) begin
         wcnt = 0;
      end else if (mem_wait >= 0 && wcnt == mem_wait) begin
         i_mem_ack   = 1'b1;
         i_mem_rdata = mem_data(o_mem_addr);
         wcnt        = 0;
      end else begin
         wcnt++;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(posedge i_clk) begin
      #1;
      if (o_m0_gnt || o_m1_gnt) begin
         chk("gnt_onehot", {63'd0, o_m0_gnt & o_m1_gnt}, 64'd0);
         if (gnt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL gnt_unexpected: m0_gnt=%0b m1_gnt=%0b required none", o_m0_gnt, o_m1_gnt);
         end else begin
            exp_gnt = gnt_q.pop_front();
            chk("gnt_idx", {63'd0, o_m1_gnt}, {63'd0, exp_gnt});
            chk("gnt_owner", {63'd0, o_owner}, {63'd0, exp_gnt});
            chk("gnt_mem_req", {63'd0, o_mem_req}, 64'd1);
         end
      end
      if (o_m0_rvalid || o_m1_rvalid) begin
         chk("rvalid_onehot", {63'd0, o_m0_rvalid & o_m1_rvalid}, 64'd0);
         chk("err_nonowner", {63'd0, o_m1_rvalid ? o_m0_err : o_m1_err}, 64'd0);
         act_rsp = o_m1_rvalid ? {1'b1, o_m1_err, o_m1_rdata} : {1'b0, o_m0_err, o_m0_rdata};
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected: got %0h required none", act_rsp);
         end else begin
            exp_rsp = exp_q.pop_front();
            chk("rsp_owner_err_rdata", 64'(act_rsp), 64'(exp_rsp));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      i_rst = 1'b1;
      drive_m0(1'b0, 1'b0, '0, '0);
      drive_m1(1'b0, 1'b0, '0, '0);
      repeat (3) tick();
      i_rst = 1'b0;

      // Reset defaults
      chk("rst_busy", {63'd0, o_busy}, 64'd0);
      chk("rst_mem_req", {63'd0, o_mem_req}, 64'd0);
      chk("rst_mem_cmd", {o_mem_wren, o_mem_addr, o_mem_wdata[30:0]}, 64'd0);
      chk("rst_owner", {63'd0, o_owner}, 64'd0);
      chk("rst_m_out", {o_m0_gnt, o_m0_rvalid, o_m0_err, o_m1_gnt, o_m1_rvalid, o_m1_err}, 64'd0);
      chk("rst_rdata", {o_m0_rdata, o_m1_rdata}, 64'd0);

      // Reset mid-ACCESS drops the pending store
      mem_wait = -1;
      gnt_q.push_back(1'b0);
      drive_m0(1'b1, 1'b1, 32'h0000_0010, 32'h0000_AA55);
      wait_gnt(1'b0);
      i_m0_req = 1'b0;
      tick();
      chk("midrst_busy_before", {63'd0, o_busy}, 64'd1);
      chk("midrst_addr_before", 64'(o_mem_addr), 64'h10);
      #3 i_rst = 1'b1;
      #1;
      chk("midrst_mem_req", {63'd0, o_mem_req}, 64'd0);
      chk("midrst_busy", {63'd0, o_busy}, 64'd0);
      chk("midrst_cmd_cleared", {o_mem_wren, o_mem_addr, o_mem_wdata[30:0]}, 64'd0);
      tick();
      i_rst = 1'b0;
      chk("midrst_outputs", {o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_owner}, 64'd0);
      tick();
      chk("midrst_no_rvalid", {o_m0_rvalid, o_m1_rvalid}, 64'd0);

      // Tie after reset grants m0; zero-wait load latency
      mem_wait = 0;
      gnt_q.push_back(1'b0);
      gnt_q.push_back(1'b1);
      exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
      exp_q.push_back({1'b1, 1'b0, 32'h0044_C0DE});
      drive_m0(1'b1, 1'b0, 32'h0000_0100, 32'h1111_1111);
      drive_m1(1'b1, 1'b0, 32'h0000_0044, 32'h2222_2222);
      tick();
      chk("zw_gnt_e1", {63'd0, o_m0_gnt}, 64'd1);
      chk("zw_mem_cmd", {o_mem_req, o_mem_wren, o_mem_addr[31:0]}, {32'd0, 1'b1, 1'b0, 32'h0000_0100});
      i_m0_req = 1'b0;
      tick();
      chk("zw_rvalid_e2", {63'd0, o_m0_rvalid}, 64'd1);
      tick();
      chk("zw_idle_e3", {o_busy, o_m0_rvalid}, 64'd0);
      chk("zw_rdata_hold", 64'(o_m0_rdata), 64'hDEAD_BEEF);
      wait_gnt(1'b1);
      i_m1_req = 1'b0;
      tick();
      wait_idle();
      chk("m0_rdata_kept", 64'(o_m0_rdata), 64'hDEAD_BEEF);

      // Wait states: m1 store, ack after 5 idle ACCESS cycles
      mem_wait = 5;
      gnt_q.push_back(1'b1);
      exp_q.push_back({1'b1, 1'b0, 32'h0000_0000});
      drive_m1(1'b1, 1'b1, 32'h0000_7000, 32'h0000_1234);
      wait_gnt(1'b1);
      i_m1_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("ws_stable", {o_mem_req, o_mem_wren, o_mem_addr[15:0], o_mem_wdata[15:0]},
             {30'd0, 1'b1, 1'b1, 16'h7000, 16'h1234});
         tick();
      end
      chk("ws_ack_cycle", {o_mem_req, o_m1_rvalid}, 64'h2);
      tick();
      chk("ws_rvalid", {o_m1_rvalid, o_m1_err}, 64'h2);
      tick();
      chk("ws_rvalid_once", {o_m1_rvalid, o_busy}, 64'd0);

      // Round-robin with both requesters held
      mem_wait = 0;
      for (int i = 0; i < 3; i++) begin
         gnt_q.push_back(1'b0);
         gnt_q.push_back(1'b1);
         exp_q.push_back({1'b0, 1'b0, 32'h0200_C0DE});
         exp_q.push_back({1'b1, 1'b0, 32'h0300_C0DE});
      end
      drive_m0(1'b1, 1'b0, 32'h0000_0200, '0);
      drive_m1(1'b1, 1'b0, 32'h0000_0300, '0);
      begin
         int n, t;
         n = 0;
         t = 0;
         while (n < 6 && t < 60) begin
            tick();
            t++;
            if (o_m0_gnt || o_m1_gnt) n++;
         end
         i_m0_req = 1'b0;
         i_m1_req = 1'b0;
         chk("rr_six_grants", 64'(n), 64'd6);
      end
      tick();
      wait_idle();

      // Late arrival: m1 raised during m0 ACCESS, granted at first IDLE edge
      mem_wait = 2;
      gnt_q.push_back(1'b0);
      gnt_q.push_back(1'b1);
      exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
      exp_q.push_back({1'b1, 1'b0, 32'h0500_C0DE});
      drive_m0(1'b1, 1'b0, 32'h0000_0100, '0);
      wait_gnt(1'b0);
      g0 = cyc;
      i_m0_req = 1'b0;
      tick();
      drive_m1(1'b1, 1'b0, 32'h0000_0500, '0);
      wait_gnt(1'b1);
      chk("late_gnt_delay", 64'(cyc - g0), 64'd5);
      i_m1_req = 1'b0;
      tick();
      wait_idle();

`ifdef ARB_TIMEOUT_EN
      // Timeout: never ack
      mem_wait = -1;
      gnt_q.push_back(1'b0);
      exp_q.push_back({1'b0, 1'b1, 32'h0000_0000});
      drive_m0(1'b1, 1'b0, 32'h0000_0100, '0);
      wait_gnt(1'b0);
      i_m0_req = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         chk("tmo_req_held", {63'd0, o_mem_req}, 64'd1);
         tick();
      end
      chk("tmo_abort", {o_mem_req, o_m0_rvalid, o_m0_err}, 64'h3);
      tick();
      wait_idle();

      // Ack on the expiry cycle wins
      mem_wait = TMO - 1;
      gnt_q.push_back(1'b0);
      exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
      drive_m0(1'b1, 1'b0, 32'h0000_0100, '0);
      wait_gnt(1'b0);
      i_m0_req = 1'b0;
      tick();
      wait_idle();
`else
      // Without the timeout, a long wait still completes normally
      mem_wait = 8;
      gnt_q.push_back(1'b0);
      exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
      drive_m0(1'b1, 1'b0, 32'h0000_0100, '0);
      wait_gnt(1'b0);
      i_m0_req = 1'b0;
      repeat (TMO + 1) tick();
      chk("notmo_req_held", {63'd0, o_mem_req}, 64'd1);
      wait_idle();
`endif

      repeat (3) tick();
      chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Two-master arbiter that shares the single LSU/data-memory port between requester 0 (core load/store path) and requester 1 (debug/program-loader port).
- Latches one command at a time and drives it to the memory side until the memory acknowledges. Returns a one-cycle completion pulse with read data to the winning requester.
- Fair round-robin arbitration when both requesters are pending. Sits between the requesters and the LSU.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYCLES, 16, ACCESS-state cycles before abort; used only with ARB_TIMEOUT_EN; range 2..255.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_m0_req  in  1  requester 0 command valid.
- i_m0_wren  in  1  requester 0 store (1) / load (0).
- i_m0_addr  in  AW  requester 0 address.
- i_m0_wdata  in  DW  requester 0 store data.
- o_m0_gnt  out  1  requester 0 command accepted (1-cycle pulse).
- o_m0_rvalid  out  1  requester 0 completion (1-cycle pulse).
- o_m0_rdata  out  DW  requester 0 load data; valid with rvalid.
- o_m0_err  out  1  requester 0 timeout error; valid with rvalid.
- i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, o_m1_gnt, o_m1_rvalid, o_m1_rdata, o_m1_err: same as requester 0, for requester 1.
- o_mem_req  out  1  memory command valid.
- o_mem_wren  out  1  memory store enable.
- o_mem_addr  out  AW  memory address.
- o_mem_wdata  out  DW  memory store data.
- i_mem_ack  in  1  memory accepted/completed the command this cycle.
- i_mem_rdata  in  DW  load data; valid with i_mem_ack.
- o_owner  out  1  index of the current or last granted requester.
- o_busy  out  1  high when FSM is not IDLE.

Behaviour:
- Reset: async i_rst forces IDLE. All outputs 0; command registers 0; last_owner=1, so requester 0 wins the first tie.
- Reset mid-transaction: the transaction is dropped. No rvalid is issued, and o_mem_req falls immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled on the clock edge.
  - One requester asserted: that requester wins.
  - Both asserted: the requester != last_owner wins.
  - On the winning edge: latch the winner's wren/addr/wdata, set owner = winner, set last_owner = winner, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - o_mem_req=1; o_mem_* driven from the latched registers and stable throughout.
  - o_mX_gnt=1 for the winner in the first ACCESS cycle only.
  - On i_mem_ack=1: capture i_mem_rdata (capture 0 for stores), go to RESP.
  - Ack may arrive in the first ACCESS cycle (zero wait).
- RESP:
  - o_mX_rvalid=1 for the owner for exactly one cycle, with o_mX_rdata and o_mX_err.
  - Next state is IDLE unconditionally.
- Outputs outside their valid cycles:
  - o_mX_rdata holds its last captured value; it is meaningful only with rvalid.
  - The non-owner's gnt/rvalid/err are always 0.
- Requester rule: hold req, wren, addr, wdata stable until gnt. Deassert req in the gnt cycle or later. A req still high when the FSM returns to IDLE is a new transaction.
- Requests arriving during ACCESS/RESP are ignored until IDLE and never lost if held.
- Latency: req sampled at edge E → gnt and o_mem_req in cycle E+1. With ack in cycle E+1, rvalid is in cycle E+2 and IDLE in E+3. Peak throughput is 1 transaction per 3 cycles.
- Alternating fairness: with both requesters held high continuously, grants alternate 0,1,0,1…
- o_busy = (state != IDLE).
- The unused memory side holds the last command values while o_mem_req=0; the memory must ignore them.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter clears on ACCESS entry and increments on each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: o_mem_req drops, go to RESP, rdata=0, o_mX_err=1 with rvalid.
  - An ack in the same cycle as expiry wins (normal completion, err=0).
- Disabled: no counter; ACCESS waits indefinitely; o_m0_err and o_m1_err are tied 0.

Decomposition:
- Package arb_pkg: state enum (IDLE, ACCESS, RESP) as a 2-bit logic typedef; owner typedef (1 bit); OWNER_M0=0, OWNER_M1=1; default TIMEOUT_CYCLES constant.
- Sub-module arb_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: grant_valid, grant_idx.
  - Reused later for the I/O bus arbiter.

Test Plan:
- Reset defaults: reset asserted mid-ACCESS (m0 store to 0x0000_0010 pending) → next cycle o_busy=0, o_mem_req=0, no rvalid, all outputs 0. The following tie grants m0.
- Single load, zero wait: m0 load addr 0x100, i_mem_ack with rdata 0xDEADBEEF in the first ACCESS cycle → gnt at E+1, o_m0_rvalid with rdata 0xDEADBEEF at E+2, IDLE at E+3.
- Wait states: m1 store addr 0x7000, wdata 0x1234, ack after 5 cycles → o_mem_* stable for 5 cycles, o_mem_wren=1, o_m1_rvalid 1 cycle after ack, err=0.
- Round-robin: both requesters held high for 6 transactions, ack immediate → grant order 0,1,0,1,0,1; o_owner matches each gnt.
- Late arrival: m1 raises req during m0's ACCESS → m1 is granted at the first IDLE edge after m0's RESP, with no lost command.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): m0 load, never ack → o_mem_req drops after 4 ACCESS cycles, o_m0_rvalid=1, err=1, rdata=0. Ack on the expiry cycle → err=0.
